// File: rtl/range_stream_sender.sv
// range_stream_sender: buffers host words, replays them as a go ... finish burst to a RangeFinder.
// Latency: go/first word one cycle after start is sampled, one word per cycle, done the cycle after finish.
// Backpressure: none downstream; wr_en/start ignored while busy or in error, rf_error aborts to a sticky error.
// Optional build macro: RANGE_SENDER_REPLAY_EN (retain buffer after a clean burst so it can be resent).

module range_stream_sender #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_start,
    input  logic                       i_clear,
    input  logic                       i_rf_error,
    output logic [WIDTH-1:0]           o_data_out,
    output logic                       o_go,
    output logic                       o_finish,
    output logic                       o_busy,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    // Registered state and outputs
    state_t           r_state;
    logic [CW-1:0]    r_count;
    // Index of the next word to drive during SEND (word 0 goes out with go)
    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_data;
    logic             r_go;
    logic             r_finish;
    logic             r_busy;
    logic             r_full;
    logic             r_done;
    logic             r_err;

    // Word storage; contents are don't-care after reset
    logic [WIDTH-1:0] r_buf [DEPTH];

    // Next-state values
    state_t           w_nxt_state;
    logic [CW-1:0]    w_nxt_count;
    logic [CW-1:0]    w_nxt_idx;
    logic [WIDTH-1:0] w_nxt_data;
    logic             w_nxt_go;
    logic             w_nxt_finish;
    logic             w_nxt_done;
    logic             w_nxt_err;
    logic             w_wr_fire;
    logic [IW-1:0]    w_wr_addr;
    logic [IW-1:0]    w_rd_addr;
    logic [CW-1:0]    w_last_idx;

    // r_idx never exceeds DEPTH-1 while reading, and writes are blocked when full,
    // so the low IW bits address the whole buffer.
    assign w_wr_addr  = r_count[IW-1:0];
    assign w_rd_addr  = r_idx[IW-1:0];
    assign w_last_idx = r_count - ONE;

    // Next-state and next-output decode; clear beats everything, then downstream error
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_count  = r_count;
        w_nxt_idx    = r_idx;
        w_nxt_data   = '0;
        w_nxt_go     = 1'b0;
        w_nxt_finish = 1'b0;
        w_nxt_done   = 1'b0;
        w_nxt_err    = r_err;
        w_wr_fire    = 1'b0;

        if (i_clear) begin
            w_nxt_state = S_IDLE;
            w_nxt_count = '0;
            w_nxt_idx   = '0;
            w_nxt_err   = 1'b0;
        end else if (i_rf_error && ((r_state == S_SEND) || r_done)) begin
            // The RangeFinder rejected the stream: abort without finish
            w_nxt_state = S_ERR;
            w_nxt_idx   = '0;
            w_nxt_err   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // start has priority over a simultaneous write
                        if (r_count >= TWO) begin
                            w_nxt_state = S_SEND;
                            w_nxt_go    = 1'b1;
                            w_nxt_data  = r_buf[0];
                            w_nxt_idx   = ONE;
                        end else begin
                            // A burst needs distinct go and finish words
                            w_nxt_state = S_ERR;
                            w_nxt_err   = 1'b1;
                        end
                    end else if (i_wr_en && !r_full) begin
                        w_wr_fire   = 1'b1;
                        w_nxt_count = r_count + ONE;
                    end
                end

                S_SEND: begin
                    if (r_finish) begin
                        // Last word is on the wire this cycle; report completion next
                        w_nxt_state = S_IDLE;
                        w_nxt_done  = 1'b1;
                        w_nxt_idx   = '0;
`ifdef RANGE_SENDER_REPLAY_EN
                        w_nxt_count = r_count;
`else
                        w_nxt_count = '0;
`endif
                    end else begin
                        w_nxt_data   = r_buf[w_rd_addr];
                        w_nxt_finish = (r_idx == w_last_idx);
                        w_nxt_idx    = r_idx + ONE;
                    end
                end

                S_ERR: begin
                    // Sticky until clear; start and wr_en are ignored
                end

                default: begin
                    w_nxt_state = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset drops every output at once
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_go     <= 1'b0;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_count  <= w_nxt_count;
            r_idx    <= w_nxt_idx;
            r_data   <= w_nxt_data;
            r_go     <= w_nxt_go;
            r_finish <= w_nxt_finish;
            r_busy   <= (w_nxt_state == S_SEND);
            r_full   <= (w_nxt_count == FULL_CNT);
            r_done   <= w_nxt_done;
            r_err    <= w_nxt_err;
        end
    end

    // Buffer write port; no reset needed on storage
    always_ff @(posedge i_clock) begin
        if (w_wr_fire) begin
            r_buf[w_wr_addr] <= i_wr_data;
        end
    end

    assign o_data_out = r_data;
    assign o_go       = r_go;
    assign o_finish   = r_finish;
    assign o_busy     = r_busy;
    assign o_full     = r_full;
    assign o_count    = r_count;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_range_stream_sender.sv
// Self-checking bench for range_stream_sender.
// Expected beats are queued when start is driven and popped as the DUT streams.
// Checks reset, bursts, short-buffer error, full, downstream error, replay, async reset.

module tb_range_stream_sender;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             clear;
    logic             rf_error;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             full;
    logic [CW-1:0]    count;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    range_stream_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_start   (start),
        .i_clear   (clear),
        .i_rf_error(rf_error),
        .o_data_out(data_out),
        .o_go      (go),
        .o_finish  (finish),
        .o_busy    (busy),
        .o_full    (full),
        .o_count   (count),
        .o_done    (done),
        .o_err     (err)
    );

    typedef struct packed {
        logic             go;
        logic             fin;
        logic [WIDTH-1:0] dat;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] mdl_buf[$];
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host write in IDLE; model keeps only the first DEPTH words
    task automatic write_word(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (mdl_buf.size() < DEPTH) mdl_buf.push_back(d);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mdl_buf.delete();
        exp_q.delete();
    endtask

    // Pulse start; queue the burst the model predicts. After return the first beat is visible.
    task automatic pulse_start();
        beat_t b;
        if (mdl_buf.size() >= 2) begin
            for (int i = 0; i < mdl_buf.size(); i++) begin
                b.go  = (i == 0);
                b.fin = (i == mdl_buf.size() - 1);
                b.dat = mdl_buf[i];
                exp_q.push_back(b);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({go, finish, busy, full, done, err, data_out, count} !== '0) begin
            n_errors++;
            $display("FAIL reset_hold got go=%b fin=%b busy=%b full=%b done=%b err=%b data=%0d count=%0d want all 0",
                     go, finish, busy, full, done, err, data_out, count);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({go, finish, busy, full, done, err, data_out, count} !== '0) begin
            n_errors++;
            $display("FAIL reset_release got go=%b fin=%b busy=%b done=%b err=%b count=%0d want all 0",
                     go, finish, busy, done, err, count);
        end
    endtask

    task automatic test_basic();
        beat_t b;
        do_clear();
        write_word(8'd5);
        write_word(8'd20);
        write_word(8'd9);
        n_checks++;
        if (count !== CW'(3)) begin
            n_errors++;
            $display("FAIL basic_count got %0d want 3", count);
        end
        pulse_start();
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            n_checks++;
            if ({go, finish, data_out, busy} !== {b.go, b.fin, b.dat, 1'b1}) begin
                n_errors++;
                $display("FAIL basic_beat got go=%b fin=%b data=%0d busy=%b want go=%b fin=%b data=%0d busy=1",
                         go, finish, data_out, busy, b.go, b.fin, b.dat);
            end
            if (exp_q.size() > 0) tick();
        end
        tick();
        n_checks++;
        if ({done, busy, go, finish, data_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL basic_done got done=%b busy=%b go=%b fin=%b data=%0d want done=1 busy=0 go=0 fin=0 data=0",
                     done, busy, go, finish, data_out);
        end
`ifdef RANGE_SENDER_REPLAY_EN
        n_checks++;
        if (count !== CW'(3)) begin
            n_errors++;
            $display("FAIL basic_count_after got %0d want 3", count);
        end
`else
        mdl_buf.delete();
        n_checks++;
        if (count !== CW'(0)) begin
            n_errors++;
            $display("FAIL basic_count_after got %0d want 0", count);
        end
`endif
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_short();
        do_clear();
        write_word(8'd7);
        pulse_start();
        n_checks++;
        if ({err, go, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL short_err got err=%b go=%b busy=%b want err=1 go=0 busy=0", err, go, busy);
        end
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            wr_en = (i == 2);
            tick();
            n_checks++;
            if ({go, err, count} !== {1'b0, 1'b1, CW'(1)}) begin
                n_errors++;
                $display("FAIL short_hold got go=%b err=%b count=%0d want go=0 err=1 count=1", go, err, count);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        do_clear();
        n_checks++;
        if ({err, count} !== {1'b0, CW'(0)}) begin
            n_errors++;
            $display("FAIL short_clear got err=%b count=%0d want err=0 count=0", err, count);
        end
    endtask

    task automatic test_full();
        beat_t b;
        int    nbeats;
        do_clear();
        for (int i = 0; i < 17; i++) begin
            write_word(8'(i * 7 + 3));
            if (i == 14 || i == 15 || i == 16) begin
                n_checks++;
                if ({full, count} !== {(i >= 15), CW'((i >= 15) ? 16 : i + 1)}) begin
                    n_errors++;
                    $display("FAIL full_fill write=%0d got full=%b count=%0d want full=%b count=%0d",
                             i + 1, full, count, (i >= 15), (i >= 15) ? 16 : i + 1);
                end
            end
        end
        pulse_start();
        nbeats = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            nbeats++;
            n_checks++;
            if ({go, finish, data_out} !== {b.go, b.fin, b.dat}) begin
                n_errors++;
                $display("FAIL full_beat %0d got go=%b fin=%b data=%0d want go=%b fin=%b data=%0d",
                         nbeats, go, finish, data_out, b.go, b.fin, b.dat);
            end
            if (exp_q.size() > 0) tick();
        end
        tick();
        n_checks++;
        if ({done, nbeats} !== {1'b1, 32'd16}) begin
            n_errors++;
            $display("FAIL full_done got done=%b beats=%0d want done=1 beats=16", done, nbeats);
        end
        do_clear();
    endtask

    task automatic test_rf_error();
        do_clear();
        write_word(8'd11);
        write_word(8'd22);
        write_word(8'd33);
        write_word(8'd44);
        pulse_start();
        n_checks++;
        if ({go, data_out} !== {1'b1, 8'd11}) begin
            n_errors++;
            $display("FAIL rferr_first got go=%b data=%0d want go=1 data=11", go, data_out);
        end
        tick();
        n_checks++;
        if ({go, finish, data_out} !== {1'b0, 1'b0, 8'd22}) begin
            n_errors++;
            $display("FAIL rferr_second got go=%b fin=%b data=%0d want go=0 fin=0 data=22", go, finish, data_out);
        end
        rf_error = 1'b1;
        tick();
        rf_error = 1'b0;
        exp_q.delete();
        n_checks++;
        if ({go, finish, data_out, err, busy} !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL rferr_abort got go=%b fin=%b data=%0d err=%b busy=%b want 0 0 0 1 0",
                     go, finish, data_out, err, busy);
        end
        for (int i = 0; i < 6; i++) begin
            start   = i[0];
            wr_en   = ~i[0];
            wr_data = 8'hA5;
            tick();
            n_checks++;
            if ({go, finish, err, count} !== {1'b0, 1'b0, 1'b1, CW'(4)}) begin
                n_errors++;
                $display("FAIL rferr_hold cyc=%0d got go=%b fin=%b err=%b count=%0d want 0 0 1 4",
                         i, go, finish, err, count);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        do_clear();
        n_checks++;
        if ({err, count} !== {1'b0, CW'(0)}) begin
            n_errors++;
            $display("FAIL rferr_clear got err=%b count=%0d want 0 0", err, count);
        end
    endtask

    task automatic test_done_error();
        do_clear();
        write_word(8'd60);
        write_word(8'd61);
        pulse_start();
        tick();
        exp_q.delete();
        n_checks++;
        if ({finish, data_out} !== {1'b1, 8'd61}) begin
            n_errors++;
            $display("FAIL doneerr_finish got fin=%b data=%0d want fin=1 data=61", finish, data_out);
        end
        tick();
        rf_error = 1'b1;
        tick();
        rf_error = 1'b0;
        n_checks++;
        if ({err, done, go} !== 3'b100) begin
            n_errors++;
            $display("FAIL doneerr_abort got err=%b done=%b go=%b want err=1 done=0 go=0", err, done, go);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({go, err, busy} !== 3'b010) begin
            n_errors++;
            $display("FAIL doneerr_start_ignored got go=%b err=%b busy=%b want 0 1 0", go, err, busy);
        end
        do_clear();
    endtask

    task automatic test_replay();
        beat_t b;
        do_clear();
        write_word(8'd5);
        write_word(8'd20);
        write_word(8'd9);
        pulse_start();
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            n_checks++;
            if ({go, finish, data_out} !== {b.go, b.fin, b.dat}) begin
                n_errors++;
                $display("FAIL replay_first got go=%b fin=%b data=%0d want go=%b fin=%b data=%0d",
                         go, finish, data_out, b.go, b.fin, b.dat);
            end
            if (exp_q.size() > 0) tick();
        end
        tick();
`ifndef RANGE_SENDER_REPLAY_EN
        mdl_buf.delete();
`endif
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL replay_done1 got done=%b want 1", done);
        end
        pulse_start();
`ifdef RANGE_SENDER_REPLAY_EN
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            n_checks++;
            if ({go, finish, data_out} !== {b.go, b.fin, b.dat}) begin
                n_errors++;
                $display("FAIL replay_second got go=%b fin=%b data=%0d want go=%b fin=%b data=%0d",
                         go, finish, data_out, b.go, b.fin, b.dat);
            end
            if (exp_q.size() > 0) tick();
        end
        tick();
        n_checks++;
        if ({done, count} !== {1'b1, CW'(3)}) begin
            n_errors++;
            $display("FAIL replay_done2 got done=%b count=%0d want done=1 count=3", done, count);
        end
`else
        n_checks++;
        if ({err, go, count} !== {1'b1, 1'b0, CW'(0)}) begin
            n_errors++;
            $display("FAIL replay_consumed got err=%b go=%b count=%0d want err=1 go=0 count=0", err, go, count);
        end
`endif
        do_clear();
    endtask

    task automatic test_reset_mid();
        do_clear();
        write_word(8'd1);
        write_word(8'd2);
        write_word(8'd3);
        pulse_start();
        tick();
        n_checks++;
        if ({busy, data_out} !== {1'b1, 8'd2}) begin
            n_errors++;
            $display("FAIL rstmid_word2 got busy=%b data=%0d want busy=1 data=2", busy, data_out);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({go, finish, busy, full, done, err, data_out, count} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_async got go=%b fin=%b busy=%b done=%b err=%b data=%0d count=%0d want all 0",
                     go, finish, busy, done, err, data_out, count);
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        mdl_buf.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({done, finish, busy, count} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
                n_errors++;
                $display("FAIL rstmid_after cyc=%0d got done=%b fin=%b busy=%b count=%0d want 0 0 0 0",
                         i, done, finish, busy, count);
            end
        end
    endtask

    initial begin
        wr_en    = 1'b0;
        wr_data  = '0;
        start    = 1'b0;
        clear    = 1'b0;
        rf_error = 1'b0;
        test_reset();
        test_basic();
        test_short();
        test_full();
        test_rf_error();
        test_done_error();
        test_replay();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
